data_exporter: RTL and testbench

DATA_EXPORTER -- requirements
Module: data_exporter

---
 rtl/data_exporter.sv | 145 ++++++++++++++
 tb/tb_data_exporter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_exporter.sv
// Serialises a latched 7*WIDTH-bit payload onto an 8-bit LED display as START, chunk, SEP, chunk, ... symbols, each held VAL cycles.
// Optional macro DATA_EXPORTER_BUSY_EN adds a registered busy output that is high while a frame is in progress.
module data_exporter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned VAL   = 12000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [7*WIDTH-1:0] data,
  output logic [7:0]         leds
`ifdef DATA_EXPORTER_BUSY_EN
  ,
  output logic               busy
`endif
);

  localparam int unsigned DATA_W = 7 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(VAL + 1);
  localparam int unsigned IDX_W  = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  localparam logic [7:0] SYM_IDLE = 8'hFF;
  localparam logic [7:0] SYM_SEP  = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_CHUNK,
    S_SEP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          leds_q;

  logic                hold_done_c;
  logic                last_chunk_c;
  logic [IDX_W-1:0]    idx_nxt_c;
  logic [6:0]          chunk_nxt_c;

  assign hold_done_c  = (cnt_q == CNT_LAST);
  assign last_chunk_c = (idx_q >= IDX_LAST);
  assign idx_nxt_c    = idx_q + IDX_W'(1);

  // Chunk shown when leaving SEP: the one after the current index.
  always_comb begin
    chunk_nxt_c = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (idx_nxt_c == IDX_W'(k)) begin
        chunk_nxt_c = data_q[7*k +: 7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      leds_q  <= SYM_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          leds_q <= SYM_IDLE;
          if (en) begin
            data_q  <= data;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (hold_done_c) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            leds_q  <= {1'b0, data_q[6:0]};
            state_q <= S_CHUNK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CHUNK: begin
          if (hold_done_c) begin
            cnt_q <= '0;
            if (last_chunk_c) begin
              leds_q  <= SYM_IDLE;
              state_q <= S_IDLE;
            end else begin
              leds_q  <= SYM_SEP;
              state_q <= S_SEP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SEP: begin
          if (hold_done_c) begin
            cnt_q   <= '0;
            idx_q   <= idx_nxt_c;
            leds_q  <= {1'b0, chunk_nxt_c};
            state_q <= S_CHUNK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          leds_q  <= SYM_IDLE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign leds = leds_q;

`ifdef DATA_EXPORTER_BUSY_EN
  logic busy_q;

  // Mirrors whether the state register holds a non-IDLE state after this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  busy_q <= en;
        S_CHUNK: busy_q <= !(hold_done_c && last_chunk_c);
        S_START: busy_q <= 1'b1;
        S_SEP:   busy_q <= 1'b1;
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_data_exporter.sv
// Scoreboard bench for data_exporter: three instances (4x5, 2x1, 1x3) with queued per-symbol expectations.
module tb_data_exporter;

  typedef struct {
    logic [7:0] leds;
    logic       busy;
    int         n;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic [27:0] data_a;
  logic [13:0] data_b;
  logic [6:0]  data_c;
  logic [7:0]  leds_a, leds_b, leds_c;
`ifdef DATA_EXPORTER_BUSY_EN
  logic busy_a, busy_b, busy_c;
`endif

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [27:0] D1 = 28'b1000_0010_0001_1110_1101_0011_0100;
  localparam logic [27:0] D2 = {7'h44, 7'h33, 7'h22, 7'h11};

  data_exporter #(.WIDTH(4), .VAL(5)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .data(data_a), .leds(leds_a)
`ifdef DATA_EXPORTER_BUSY_EN
    , .busy(busy_a)
`endif
  );

  data_exporter #(.WIDTH(2), .VAL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .data(data_b), .leds(leds_b)
`ifdef DATA_EXPORTER_BUSY_EN
    , .busy(busy_b)
`endif
  );

  data_exporter #(.WIDTH(1), .VAL(3)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .data(data_c), .leds(leds_c)
`ifdef DATA_EXPORTER_BUSY_EN
    , .busy(busy_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int which, input logic [7:0] l, input logic b, input int n);
    exp_t e;
    e.leds = l;
    e.busy = b;
    e.n    = n;
    case (which)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Expected symbols of one instance-A frame with hand-computed chunk values.
  task automatic frame_a(input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
    push(0, 8'hFF, 1'b1, 5);
    push(0, c0,    1'b1, 5);
    push(0, 8'h80, 1'b1, 5);
    push(0, c1,    1'b1, 5);
    push(0, 8'h80, 1'b1, 5);
    push(0, c2,    1'b1, 5);
    push(0, 8'h80, 1'b1, 5);
    push(0, c3,    1'b1, 5);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) begin
        empty = 1'b1;
        break;
      end
      @(posedge clk);
    end
    n_checks++;
    if (!empty) begin
      n_errors++;
      $display("FAIL drain: pending a=%0d b=%0d c=%0d expected all 0", qa.size(), qb.size(), qc.size());
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      check8("A.leds", leds_a, e.leds);
`ifdef DATA_EXPORTER_BUSY_EN
      check1("A.busy", busy_a, e.busy);
`endif
      if (e.n > 1) begin
        e.n--;
        qa.push_front(e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (qb.size() != 0) begin
      e = qb.pop_front();
      check8("B.leds", leds_b, e.leds);
`ifdef DATA_EXPORTER_BUSY_EN
      check1("B.busy", busy_b, e.busy);
`endif
      if (e.n > 1) begin
        e.n--;
        qb.push_front(e);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (qc.size() != 0) begin
      e = qc.pop_front();
      check8("C.leds", leds_c, e.leds);
`ifdef DATA_EXPORTER_BUSY_EN
      check1("C.busy", busy_c, e.busy);
`endif
      if (e.n > 1) begin
        e.n--;
        qc.push_front(e);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    en_c   = 1'b0;
    data_a = '0;
    data_b = '0;
    data_c = '0;

    // Reset state, then a single-pulse frame with data changed right after the latch.
    repeat (2) @(posedge clk);
    push(0, 8'hFF, 1'b0, 1);
    push(1, 8'hFF, 1'b0, 1);
    push(2, 8'hFF, 1'b0, 1);
    frame_a(8'h34, 8'h5A, 8'h07, 8'h41);
    push(0, 8'hFF, 1'b0, 10);
    #1;
    rst_n  = 1'b1;
    en_a   = 1'b1;
    data_a = D1;
    @(posedge clk);
    #1;
    en_a   = 1'b0;
    data_a = 28'h5555555;
    drain();

    // en held high: back-to-back frames, one IDLE cycle between, data re-latched.
    @(posedge clk);
    push(0, 8'hFF, 1'b0, 1);
    frame_a(8'h34, 8'h5A, 8'h07, 8'h41);
    push(0, 8'hFF, 1'b0, 1);
    frame_a(8'h11, 8'h22, 8'h33, 8'h44);
    push(0, 8'hFF, 1'b0, 5);
    #1;
    en_a   = 1'b1;
    data_a = D1;
    @(posedge clk);
    #1;
    data_a = D2;
    repeat (45) @(posedge clk);
    #1;
    en_a = 1'b0;
    drain();

    // Reset during chunk1 aborts the frame, wins over en, and nothing follows.
    @(posedge clk);
    push(0, 8'hFF, 1'b0, 1);
    push(0, 8'hFF, 1'b1, 5);
    push(0, 8'h34, 1'b1, 5);
    push(0, 8'h80, 1'b1, 5);
    push(0, 8'h5A, 1'b1, 1);
    push(0, 8'hFF, 1'b0, 20);
    #1;
    en_a   = 1'b1;
    data_a = D1;
    @(posedge clk);
    #1;
    en_a = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    en_a  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_a  = 1'b0;
    drain();

    // VAL=1, WIDTH=2, en held: IDLE, START, 7F, 80, 7F repeating.
    @(posedge clk);
    for (int f = 0; f < 3; f++) begin
      push(1, 8'hFF, 1'b0, 1);
      push(1, 8'hFF, 1'b1, 1);
      push(1, 8'h7F, 1'b1, 1);
      push(1, 8'h80, 1'b1, 1);
      push(1, 8'h7F, 1'b1, 1);
    end
    push(1, 8'hFF, 1'b0, 5);
    #1;
    en_b   = 1'b1;
    data_b = 14'h3FFF;
    repeat (15) @(posedge clk);
    #1;
    en_b = 1'b0;
    drain();

    // WIDTH=1: a single chunk and no SEP symbol.
    @(posedge clk);
    push(2, 8'hFF, 1'b0, 1);
    push(2, 8'hFF, 1'b1, 3);
    push(2, 8'h2A, 1'b1, 3);
    push(2, 8'hFF, 1'b0, 4);
    #1;
    en_c   = 1'b1;
    data_c = 7'h2A;
    @(posedge clk);
    #1;
    en_c   = 1'b0;
    data_c = 7'h55;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
